// File: rtl/sme_pkg.sv
// Shared types and constants for the sme_multi string-matching engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sme_pkg;

    localparam int SME_CHAR_W = 8;

    typedef logic [SME_CHAR_W-1:0] sme_char_t;

    // Pattern metacharacters and the word-boundary character.
    localparam sme_char_t CH_SPACE = 8'h20;
    localparam sme_char_t CH_DOT   = 8'h2E;
    localparam sme_char_t CH_HEAD  = 8'h5E;
    localparam sme_char_t CH_TAIL  = 8'h24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_S,
        ST_LOAD_P,
        ST_SCAN,
        ST_EMIT
    } sme_state_t;

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with flush; rd_dat shows the head entry combinationally.
// Latency: a write is visible at rd_dat the cycle after it is accepted.
// Backpressure: writes when full and reads when empty are ignored; count tells the caller.
//
// Ports: clk, reset (sync, active-low), clr (sync flush), wr_vld/wr_dat (push),
//        rd_rdy (pop), rd_dat (head entry), count (entries held).
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign do_wr  = wr_vld && (count != CW'(DEPTH));
    assign do_rd  = rd_rdy && (count != '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            if (do_wr && !do_rd)      count <= count + CW'(1);
            else if (do_rd && !do_wr) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/sme_char_cmp.sv
// Single text-vs-pattern character comparison; '.' in the pattern matches anything.
// Latency: combinational.
// Backpressure: none.
//
// Ports: str_char (text character), pat_char (pattern character), hit (characters match).
// Build option: SME_CASE_FOLD_EN makes ASCII letters compare case-insensitively.
module sme_char_cmp
    import sme_pkg::*;
#(
    parameter int CHAR_W = 8
) (
    input  logic [CHAR_W-1:0] str_char,
    input  logic [CHAR_W-1:0] pat_char,
    output logic              hit
);

    localparam logic [CHAR_W-1:0] DOT = CHAR_W'(CH_DOT);

`ifdef SME_CASE_FOLD_EN
    localparam logic [CHAR_W-1:0] CASE_BIT = CHAR_W'(8'h20);
    localparam logic [CHAR_W-1:0] LO_A     = CHAR_W'(8'h61);
    localparam logic [CHAR_W-1:0] LO_Z     = CHAR_W'(8'h7A);

    logic [CHAR_W-1:0] s_low;
    logic [CHAR_W-1:0] p_low;
    logic              s_letter;
    logic              p_letter;

    // Forcing bit 5 maps A-Z onto a-z; only fold when both sides are letters
    // so punctuation pairs such as '@'/'`' stay distinct.
    always_comb begin
        s_low    = str_char | CASE_BIT;
        p_low    = pat_char | CASE_BIT;
        s_letter = (s_low >= LO_A) && (s_low <= LO_Z);
        p_letter = (p_low >= LO_A) && (p_low <= LO_Z);
        hit      = (pat_char == DOT) || (str_char == pat_char) ||
                   (s_letter && p_letter && (s_low == p_low));
    end
`else
    assign hit = (pat_char == DOT) || (str_char == pat_char);
`endif

endmodule

// File: rtl/sme_multi.sv
// String-matching engine: buffers a string and a pattern, scans every start position, emits all hits in order.
// Latency: scan of <= MAX_STR*(MAX_PAT+1) cycles, then one registered result beat per cycle.
// Backpressure: none; any strobe during SCAN/EMIT aborts the search and loads that character.
//
// Ports: clk, reset (sync, active-low), chardata + isstring/ispattern (load strobes, string wins),
//        valid/match/match_index/last (result beats), busy (SCAN or EMIT in progress).
// Build option: SME_CASE_FOLD_EN enables ASCII case-insensitive compares (see sme_char_cmp).
module sme_multi
    import sme_pkg::*;
#(
    parameter  int CHAR_W  = 8,
    parameter  int MAX_STR = 32,
    parameter  int MAX_PAT = 8,
    localparam int IDX_W   = $clog2(MAX_STR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    output logic              valid,
    output logic              match,
    output logic [IDX_W-1:0]  match_index,
    output logic              last,
    output logic              busy
);

    localparam int LW  = IDX_W + 1;                        // holds 0..MAX_STR
    localparam int KW  = $clog2(MAX_PAT + 1);              // holds 0..MAX_PAT
    localparam int PIW = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;
    localparam int PSW = $clog2(MAX_STR + MAX_PAT) + 1;    // holds p+k without wrap

    localparam logic [CHAR_W-1:0] SPACE = CHAR_W'(CH_SPACE);
    localparam logic [CHAR_W-1:0] HEAD  = CHAR_W'(CH_HEAD);
    localparam logic [CHAR_W-1:0] TAIL  = CHAR_W'(CH_TAIL);

    sme_state_t state;
    sme_state_t state_nxt;

    logic [CHAR_W-1:0] str_mem [MAX_STR];
    logic [CHAR_W-1:0] pat_mem [MAX_PAT];
    logic [LW-1:0]     str_len;
    logic [KW-1:0]     pat_len;
    logic              head_anc;
    logic              tail_anc;
    logic [LW-1:0]     scan_p;
    logic [KW-1:0]     scan_k;

    logic              strobe;
    logic              scan_entry;
    logic [KW-1:0]     pat_wr_len;
    logic [PSW-1:0]    pos;
    logic [IDX_W-1:0]  prev_idx;
    logic [CHAR_W-1:0] str_at_pos;
    logic [CHAR_W-1:0] pat_at_k;
    logic              char_hit;
    logic              at_end;
    logic              cand;
    logic              head_ok;
    logic              tail_ok;
    logic              advance;
    logic              scan_done;
    logic              hit_push;
    logic              pop;
    logic [IDX_W-1:0]  fifo_dat;
    logic [LW-1:0]     fifo_cnt;

    assign strobe     = isstring || ispattern;
    assign scan_entry = (state_nxt == ST_SCAN) && (state != ST_SCAN);
    // A pattern burst restarts unless it continues one already in progress.
    assign pat_wr_len = (state != ST_LOAD_P) ? '0 : pat_len;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (isstring) begin
            state_nxt = ST_LOAD_S;
        end else if (ispattern) begin
            state_nxt = ST_LOAD_P;
        end else begin
            case (state)
                ST_LOAD_S, ST_LOAD_P: state_nxt = ST_SCAN;
                ST_SCAN:              if (scan_done) state_nxt = ST_EMIT;
                ST_EMIT:              if (last) state_nxt = ST_IDLE;
                default:              state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- scan datapath ----------------
    always_comb begin
        pos        = PSW'(scan_p) + PSW'(scan_k);
        prev_idx   = scan_p[IDX_W-1:0] - IDX_W'(1);
        str_at_pos = str_mem[pos[IDX_W-1:0]];
        pat_at_k   = pat_mem[scan_k[PIW-1:0]];
        at_end     = (pos >= PSW'(str_len));
        cand       = (scan_k == pat_len);
        head_ok    = !head_anc || (scan_p == '0) || (str_mem[prev_idx] == SPACE);
        // str_at_pos is a wrapped read when at_end; the OR makes it irrelevant then.
        tail_ok    = !tail_anc || at_end || (str_at_pos == SPACE);
        // Candidate is checked before end-of-string so a hit flush with the end counts.
        advance    = cand || at_end || !char_hit;
        scan_done  = (str_len == '0) || (advance && ((scan_p + LW'(1)) >= str_len));
        hit_push   = (state == ST_SCAN) && !strobe && (scan_p < str_len) &&
                     cand && (pat_len != '0) && head_ok && tail_ok;
        pop        = (state == ST_EMIT) && !strobe && !last && (fifo_cnt != '0);
    end

    sme_char_cmp #(.CHAR_W(CHAR_W)) u_cmp (
        .str_char (str_at_pos),
        .pat_char (pat_at_k),
        .hit      (char_hit)
    );

    fifo #(.W(IDX_W), .DEPTH(MAX_STR)) u_hits (
        .clk    (clk),
        .reset  (reset),
        .clr    (scan_entry),
        .wr_vld (hit_push),
        .wr_dat (scan_p[IDX_W-1:0]),
        .rd_rdy (pop),
        .rd_dat (fifo_dat),
        .count  (fifo_cnt)
    );

    // ---------------- buffers and scan pointers ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MAX_STR; i++) str_mem[i] <= '0;
            for (int i = 0; i < MAX_PAT; i++) pat_mem[i] <= '0;
            str_len  <= '0;
            pat_len  <= '0;
            head_anc <= 1'b0;
            tail_anc <= 1'b0;
            scan_p   <= '0;
            scan_k   <= '0;
        end else begin
            if (isstring) begin
                if (state != ST_LOAD_S) begin
                    str_mem[0] <= chardata;
                    str_len    <= LW'(1);
                end else if (str_len < LW'(MAX_STR)) begin
                    str_mem[str_len[IDX_W-1:0]] <= chardata;
                    str_len <= str_len + LW'(1);
                end
            end else if (ispattern) begin
                if (state != ST_LOAD_P) begin
                    head_anc <= 1'b0;
                    tail_anc <= 1'b0;
                    pat_len  <= '0;
                end
                // Later assignments override the restart clears above.
                if (chardata == HEAD) begin
                    head_anc <= 1'b1;
                end else if (chardata == TAIL) begin
                    tail_anc <= 1'b1;
                end else if (pat_wr_len < KW'(MAX_PAT)) begin
                    pat_mem[pat_wr_len[PIW-1:0]] <= chardata;
                    pat_len <= pat_wr_len + KW'(1);
                end
            end

            if (scan_entry) begin
                scan_p <= '0;
                scan_k <= '0;
            end else if (state == ST_SCAN) begin
                if (advance) begin
                    scan_p <= scan_p + LW'(1);
                    scan_k <= '0;
                end else begin
                    scan_k <= scan_k + KW'(1);
                end
            end
        end
    end

    // ---------------- registered result beats ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
            last        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
            last        <= 1'b0;
            // With an empty FIFO this produces the single no-match beat.
            if ((state == ST_EMIT) && !strobe && !last) begin
                valid       <= 1'b1;
                match       <= (fifo_cnt != '0);
                match_index <= (fifo_cnt != '0) ? fifo_dat : '0;
                last        <= (fifo_cnt <= LW'(1));
                if (fifo_cnt <= LW'(1)) busy <= 1'b0;
            end
            if (scan_entry)  busy <= 1'b1;
            else if (strobe) busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sme_multi.sv
module tb_sme_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       valid;
    logic       match;
    logic [4:0] match_index;
    logic       last;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Beats recorded by collect()
    int         n_beats;
    int         first_cyc;
    logic       timed_out;
    logic       b_match [16];
    logic [4:0] b_idx   [16];
    logic       b_last  [16];
    logic       b_busy  [16];

    always #5 clk = ~clk;

    sme_multi dut (
        .clk         (clk),
        .reset       (reset),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .valid       (valid),
        .match       (match),
        .match_index (match_index),
        .last        (last),
        .busy        (busy)
    );

    task automatic drive(input logic s, input logic p, input logic [7:0] c);
        @(negedge clk);
        isstring  = s;
        ispattern = p;
        chardata  = c;
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) drive(1'b1, 1'b0, s[i]);
    endtask

    task automatic load_pat(input string s);
        for (int i = 0; i < s.len(); i++) drive(1'b0, 1'b1, s[i]);
    endtask

    // Drives the idle cycle that starts the search, then records beats until last or budget.
    task automatic collect(input int budget);
        n_beats   = 0;
        first_cyc = -1;
        timed_out = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = c;
                if (n_beats < 16) begin
                    b_match[n_beats] = match;
                    b_idx[n_beats]   = match_index;
                    b_last[n_beats]  = last;
                    b_busy[n_beats]  = busy;
                end
                n_beats++;
                if (last === 1'b1) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; isstring = 1'b0; ispattern = 1'b0; chardata = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid, match, last, busy} !== 4'b0000 || match_index !== 5'd0) begin
            failures++;
            $display("FAIL reset_outputs: valid/match/last/busy=%b idx=%0d, expected 0000 idx 0",
                     {valid, match, last, busy}, match_index);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: valid=%b busy=%b, expected 0 0", valid, busy);
        end
    endtask

    task automatic test_overlap();
        load_str("aaa");
        load_pat("aa");
        collect(1000);
        checks++;
        if (timed_out !== 1'b0 || n_beats !== 2) begin
            failures++;
            $display("FAIL overlap_count: beats=%0d timeout=%b, expected 2 beats", n_beats, timed_out);
        end
        checks++;
        if (b_match[0] !== 1'b1 || b_idx[0] !== 5'd0 || b_last[0] !== 1'b0) begin
            failures++;
            $display("FAIL overlap_beat0: match=%b idx=%0d last=%b, expected 1 0 0", b_match[0], b_idx[0], b_last[0]);
        end
        checks++;
        if (b_match[1] !== 1'b1 || b_idx[1] !== 5'd1 || b_last[1] !== 1'b1) begin
            failures++;
            $display("FAIL overlap_beat1: match=%b idx=%0d last=%b, expected 1 1 1", b_match[1], b_idx[1], b_last[1]);
        end
        // Scan: p0 3 cycles, p1 3 cycles, p2 2 cycles, then one cycle to register the beat.
        checks++;
        if (first_cyc !== 10) begin
            failures++;
            $display("FAIL overlap_latency: first beat at cycle %0d, expected 10", first_cyc);
        end
        checks++;
        if (b_busy[0] !== 1'b1 || b_busy[1] !== 1'b0) begin
            failures++;
            $display("FAIL overlap_busy: busy at beats=%b%b, expected 10", b_busy[0], b_busy[1]);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL overlap_after: valid=%b busy=%b, expected 0 0", valid, busy);
        end
    endtask

    task automatic test_head_anchor();
        // "hat" at 8 follows a space, so it is a second hit alongside "cat" at 4.
        load_str("the cat hat");
        load_pat("^.at");
        collect(1000);
        checks++;
        if (timed_out !== 1'b0 || n_beats !== 2 || b_idx[0] !== 5'd4 || b_idx[1] !== 5'd8 ||
            b_match[0] !== 1'b1 || b_last[1] !== 1'b1) begin
            failures++;
            $display("FAIL head_hat: beats=%0d idx0=%0d idx1=%0d, expected 2 beats idx 4,8", n_beats, b_idx[0], b_idx[1]);
        end
        // "hat" at 9 follows 'c' and must be rejected.
        load_str("the cat chat");
        load_pat("^.at");
        collect(1000);
        checks++;
        if (timed_out !== 1'b0 || n_beats !== 1 || b_match[0] !== 1'b1 || b_idx[0] !== 5'd4) begin
            failures++;
            $display("FAIL head_chat: beats=%0d match=%b idx=%0d, expected 1 beat match idx 4", n_beats, b_match[0], b_idx[0]);
        end
    endtask

    task automatic test_tail_anchor();
        load_str("abc abd");
        load_pat("ab$");
        collect(1000);
        checks++;
        if (timed_out !== 1'b0 || n_beats !== 1 || b_match[0] !== 1'b0 || b_idx[0] !== 5'd0 || b_last[0] !== 1'b1) begin
            failures++;
            $display("FAIL tail_nomatch: beats=%0d match=%b idx=%0d last=%b, expected 1 beat 0 0 1",
                     n_beats, b_match[0], b_idx[0], b_last[0]);
        end
        load_pat("abd$");
        collect(1000);
        checks++;
        if (timed_out !== 1'b0 || n_beats !== 1 || b_match[0] !== 1'b1 || b_idx[0] !== 5'd4) begin
            failures++;
            $display("FAIL tail_retained: beats=%0d match=%b idx=%0d, expected 1 beat match idx 4", n_beats, b_match[0], b_idx[0]);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 40; i++)
            drive(1'b1, 1'b0, (i < 30) ? 8'h78 : (i == 30) ? 8'h79 : (i == 31) ? 8'h7A : 8'h71);
        load_pat("yz$");
        collect(2000);
        checks++;
        if (timed_out !== 1'b0 || n_beats !== 1 || b_match[0] !== 1'b1 || b_idx[0] !== 5'd30) begin
            failures++;
            $display("FAIL sat_tail: beats=%0d match=%b idx=%0d, expected 1 beat match idx 30", n_beats, b_match[0], b_idx[0]);
        end
        load_pat("yzq");
        collect(2000);
        checks++;
        if (timed_out !== 1'b0 || n_beats !== 1 || b_match[0] !== 1'b0) begin
            failures++;
            $display("FAIL sat_dropped: beats=%0d match=%b, expected 1 beat no match", n_beats, b_match[0]);
        end
    endtask

    task automatic test_wildcard_empty();
        load_str("cat");
        load_pat("^$");
        collect(1000);
        checks++;
        if (timed_out !== 1'b0 || n_beats !== 1 || b_match[0] !== 1'b0 || b_last[0] !== 1'b1) begin
            failures++;
            $display("FAIL empty_pat: beats=%0d match=%b last=%b, expected 1 beat 0 1", n_beats, b_match[0], b_last[0]);
        end
        load_pat("...");
        collect(1000);
        checks++;
        if (timed_out !== 1'b0 || n_beats !== 1 || b_match[0] !== 1'b1 || b_idx[0] !== 5'd0) begin
            failures++;
            $display("FAIL wildcard: beats=%0d match=%b idx=%0d, expected 1 beat match idx 0", n_beats, b_match[0], b_idx[0]);
        end
    endtask

    task automatic test_case_fold();
        logic exp_m;
`ifdef SME_CASE_FOLD_EN
        exp_m = 1'b1;
`else
        exp_m = 1'b0;
`endif
        load_str("cat");
        load_pat("Cat");
        collect(1000);
        checks++;
        if (timed_out !== 1'b0 || n_beats !== 1 || b_match[0] !== exp_m || b_idx[0] !== 5'd0) begin
            failures++;
            $display("FAIL case_fold: beats=%0d match=%b idx=%0d, expected 1 beat match=%b idx 0",
                     n_beats, b_match[0], b_idx[0], exp_m);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 8'h61);
        load_pat("a");
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_scan_busy: busy=%b valid=%b, expected 1 0", busy, valid);
        end
        isstring = 1'b1; chardata = 8'h62;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_drop: busy=%b valid=%b, expected 0 0", busy, valid);
        end
        // New string is just "b": aborted hits must never appear.
        collect(1000);
        checks++;
        if (timed_out !== 1'b0 || n_beats !== 1 || b_match[0] !== 1'b0) begin
            failures++;
            $display("FAIL abort_restart: beats=%0d match=%b, expected 1 beat no match", n_beats, b_match[0]);
        end
    endtask

    task automatic test_reset_mid_emit();
        int waited;
        load_str("aaa");
        load_pat("a");
        drive(1'b0, 1'b0, 8'h00);
        waited = 0;
        while (valid !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (valid !== 1'b1 || match !== 1'b1 || match_index !== 5'd0) begin
            failures++;
            $display("FAIL rst_emit_beat: valid=%b match=%b idx=%0d, expected 1 1 0", valid, match, match_index);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid, match, last, busy} !== 4'b0000 || match_index !== 5'd0) begin
            failures++;
            $display("FAIL rst_emit_clear: valid/match/last/busy=%b idx=%0d, expected 0000 idx 0",
                     {valid, match, last, busy}, match_index);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_emit_quiet: valid=%b busy=%b, expected 0 0", valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_head_anchor();
        test_tail_anchor();
        test_saturate();
        test_wildcard_empty();
        test_case_fold();
        test_abort();
        test_reset_mid_emit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
